fifox_wr_arbiter: RTL and testbench



---
 rtl/fifox_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifox_wr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifox_wr_arbiter.sv
// ============================================================================
//  Module   : fifox_wr_arbiter
//  Brief    : Round-robin, burst-locked write arbiter in front of one FIFOX.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifox_wr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int INPUTS     = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INPUTS*DATA_WIDTH-1:0] rx_data,
    input  logic [INPUTS-1:0]            rx_src_rdy,
    output logic [INPUTS-1:0]            rx_dst_rdy,
    output logic [DATA_WIDTH-1:0]        fifo_di,
    output logic                         fifo_wr,
    input  logic                         fifo_full,
    output logic [INPUTS-1:0]            grant,
    output logic [$clog2(MAX_BURST):0]   burst_cnt
);

    localparam int c_ptr_w = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int c_cnt_w = $clog2(MAX_BURST) + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_rst  = c_ptr_w'(INPUTS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAX_BURST - 1);
    localparam logic [c_ptr_w:0]   c_inputs   = (c_ptr_w + 1)'(INPUTS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_ptr_w-1:0]   r_ptr;
    logic [c_ptr_w-1:0]   w_ptr_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_ptr_w-1:0]   w_hit;
    logic                 w_found;
    logic [c_ptr_w:0]     w_idx;
    logic                 w_sel_rdy;
    logic [DATA_WIDTH-1:0] w_lane [INPUTS];

    genvar gi;
    generate
        for (gi = 0; gi < INPUTS; gi++) begin : g_lane
            assign w_lane[gi] = rx_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin scan starting just after the last winner; the index is one
    // bit wider than ptr so ptr+k never overflows before the modulo wrap.
    always_comb begin
        w_found = 1'b0;
        w_hit   = r_ptr;
        w_idx   = '0;
        for (int k = 1; k <= INPUTS; k++) begin
            w_idx = {1'b0, r_ptr} + (c_ptr_w + 1)'(k);
            if (w_idx >= c_inputs) begin
                w_idx = w_idx - c_inputs;
            end
            if (!w_found && rx_src_rdy[w_idx[c_ptr_w-1:0]]) begin
                w_found = 1'b1;
                w_hit   = w_idx[c_ptr_w-1:0];
            end
        end
    end

    assign w_sel_rdy = rx_src_rdy[r_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        rx_dst_rdy  = '0;
        fifo_di     = '0;
        fifo_wr     = 1'b0;
        grant       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_BURST;
                    w_ptr_nxt   = w_hit;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BURST: begin
                grant[r_ptr]      = 1'b1;
                rx_dst_rdy[r_ptr] = ~fifo_full;
                fifo_di           = w_lane[r_ptr];
                fifo_wr           = w_sel_rdy & ~fifo_full;
                // A full stall with the owner still valid holds everything.
                if (!w_sel_rdy) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (!fifo_full) begin
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= c_ptr_rst;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign burst_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifox_wr_arbiter.sv
// ============================================================================
//  Module   : tb_fifox_wr_arbiter
//  Brief    : Self-checking bench: directed vector table plus random model run.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifox_wr_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*DW-1:0] rx_data;
    logic [N-1:0]  src;
    logic [N-1:0]  dst;
    logic [N-1:0]  grant;
    logic [DW-1:0] di;
    logic          wr;
    logic          full;
    logic [2:0]    bcnt;

    logic [2*DW-1:0] data1;
    logic [1:0]    src1;
    logic [1:0]    dst1;
    logic [1:0]    grant1;
    logic [DW-1:0] di1;
    logic          wr1;
    logic          full1;
    logic [0:0]    bcnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifox_wr_arbiter #(.DATA_WIDTH(DW), .INPUTS(N), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(rst), .rx_data(rx_data), .rx_src_rdy(src),
        .rx_dst_rdy(dst), .fifo_di(di), .fifo_wr(wr), .fifo_full(full),
        .grant(grant), .burst_cnt(bcnt)
    );

    fifox_wr_arbiter #(.DATA_WIDTH(DW), .INPUTS(2), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset(rst), .rx_data(data1), .rx_src_rdy(src1),
        .rx_dst_rdy(dst1), .fifo_di(di1), .fifo_wr(wr1), .fifo_full(full1),
        .grant(grant1), .burst_cnt(bcnt1)
    );

    typedef struct {
        logic       rst;
        logic [3:0] src;
        logic       full;
        logic [3:0] grant;
        logic [3:0] dst;
        logic       wr;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [3:0] s, input logic f,
                                input logic [3:0] g, input logic [3:0] d,
                                input logic w, input logic [2:0] c);
        vec_t v;
        v.rst = r; v.src = s; v.full = f; v.grant = g; v.dst = d; v.wr = w; v.cnt = c;
        tbl.push_back(v);
    endfunction

    function automatic void idle(input logic [3:0] s);
        add(1'b0, s, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0);
    endfunction

    function automatic void beat(input logic [3:0] s, input logic [3:0] g, input logic [2:0] c);
        add(1'b0, s, 1'b0, g, g, 1'b1, c);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: owner index (-1 when nobody holds the FIFO), last winner,
    // and items already written in the current burst.
    int m_owner;
    int m_last;
    int m_items;
    logic [3:0] eg, ed;
    logic       ew;
    logic [2:0] ec;
    logic [DW-1:0] edi;
    logic [3:0] tg;

    task automatic model_step();
        int c;
        bit hit;
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_items = 0;
        end else if (m_owner < 0) begin
            hit = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!hit && src[c]) begin
                    hit = 1; m_owner = c; m_last = c; m_items = 0;
                end
            end
        end else if (!src[m_owner]) begin
            m_owner = -1; m_items = 0;
        end else if (!full) begin
            m_items++;
            if (m_items == MB) begin
                m_owner = -1; m_items = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; src = '0; full = 1'b0; rx_data = {8'h44, 8'h33, 8'h22, 8'h11};
        src1 = '0; full1 = 1'b0; data1 = {8'hB1, 8'hA0};
        repeat (2) @(negedge clk);

        add(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0);
        // All inputs busy: one bubble then four beats per owner, 0..3.
        for (int b = 0; b < 4; b++) begin
            idle(4'b1111);
            for (int c = 0; c < 4; c++) beat(4'b1111, 4'(1 << b), 3'(c));
        end
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0);
        // Lone input 2, six items.
        idle(4'b0100);
        for (int c = 0; c < 4; c++) beat(4'b0100, 4'b0100, 3'(c));
        idle(4'b0100);
        beat(4'b0100, 4'b0100, 3'd0);
        beat(4'b0100, 4'b0100, 3'd1);
        add(1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b0, 3'd2);
        idle(4'b0000);
        // Input 1 stalled by FULL at cnt=2.
        idle(4'b0010);
        beat(4'b0010, 4'b0010, 3'd0);
        beat(4'b0010, 4'b0010, 3'd1);
        for (int c = 0; c < 5; c++) add(1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b0, 3'd2);
        beat(4'b0010, 4'b0010, 3'd2);
        beat(4'b0010, 4'b0010, 3'd3);
        idle(4'b0000);
        // Input 3 drops after one item; wrap-around to input 0.
        idle(4'b1001);
        beat(4'b1001, 4'b1000, 3'd0);
        add(1'b0, 4'b0001, 1'b0, 4'b1000, 4'b1000, 1'b0, 3'd1);
        idle(4'b0001);
        beat(4'b0001, 4'b0001, 3'd0);
        add(1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b0, 3'd1);
        idle(4'b0000);
        // Reset mid-burst from input 2, input 1 waiting.
        idle(4'b0100);
        beat(4'b0110, 4'b0100, 3'd0);
        add(1'b1, 4'b0110, 1'b0, 4'b0100, 4'b0100, 1'b1, 3'd1);
        idle(4'b0110);
        beat(4'b0110, 4'b0010, 3'd0);
        add(1'b0, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b0, 3'd1);
        idle(4'b0000);
        // Reset mid-burst from input 2, input 0 waiting.
        idle(4'b0100);
        beat(4'b0101, 4'b0100, 3'd0);
        add(1'b1, 4'b0101, 1'b0, 4'b0100, 4'b0100, 1'b1, 3'd1);
        idle(4'b0101);
        beat(4'b0101, 4'b0001, 3'd0);
        add(1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b0, 3'd1);
        idle(4'b0000);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; src = tbl[i].src; full = tbl[i].full;
            #1;
            check($sformatf("vec%0d {grant,dst,wr,cnt}", i), 64'({grant, dst, wr, bcnt}),
                  64'({tbl[i].grant, tbl[i].dst, tbl[i].wr, tbl[i].cnt}));
            if (tbl[i].grant != 4'b0000) begin
                tg = tbl[i].grant;
                edi = '0;
                for (int j = 0; j < N; j++) if (tg[j]) edi = rx_data[j*DW +: DW];
                check($sformatf("vec%0d fifo_di", i), 64'(di), 64'(edi));
            end
        end

        // MAX_BURST=1 instance: strict alternation W0, idle, W1, idle.
        @(negedge clk);
        rst = 1'b0; src = '0; src1 = 2'b11;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k % 2 == 1) begin
                check($sformatf("mb1 cyc%0d {grant,dst,wr,cnt}", k), 64'({grant1, dst1, wr1, bcnt1}),
                      64'({2'(1 << ((k / 2) % 2)), 2'(1 << ((k / 2) % 2)), 1'b1, 1'b0}));
                check($sformatf("mb1 cyc%0d fifo_di", k), 64'(di1),
                      64'(((k / 2) % 2 == 0) ? 8'hA0 : 8'hB1));
            end else begin
                check($sformatf("mb1 cyc%0d idle", k), 64'({grant1, dst1, wr1}), 64'(0));
            end
            @(negedge clk);
        end
        src1 = '0;

        // Random run against the reference model.
        rst = 1'b1;
        @(negedge clk);
        m_owner = -1; m_last = N - 1; m_items = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst  = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) src[i] = ($urandom_range(0, 9) < 8);
            full = ($urandom_range(0, 3) == 0);
            rx_data = $urandom;
            #1;
            eg = '0; ed = '0; ew = 1'b0; ec = '0;
            if (m_owner >= 0) begin
                eg = 4'(1 << m_owner);
                ed = full ? 4'b0000 : eg;
                ew = src[m_owner] && !full;
                ec = 3'(m_items);
                check($sformatf("rand%0d fifo_di", cyc), 64'(di), 64'(rx_data[m_owner*DW +: DW]));
            end
            check($sformatf("rand%0d {grant,dst,wr,cnt}", cyc), 64'({grant, dst, wr, bcnt}),
                  64'({eg, ed, ew, ec}));
            model_step();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
